// File: rtl/iddr_loopback_sequencer.sv
// IDDR loopback self-test controller: PRBS7 pair source for the ODDR, IDDR R/CE
// sequencing, linear capture-latency search and a saturating mismatch counter.
module iddr_loopback_sequencer #(
    parameter int         RST_CYCLES    = 4,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         ALIGN_LEN     = 16,
    parameter int         MAX_LAT       = 7,
    parameter int         CHECK_LEN     = 256,
    parameter logic [6:0] SEED          = 7'h7F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        iddr_rst,
    output logic        iddr_ce,
    output logic        tx_d1,
    output logic        tx_d2,
    input  logic        rx_q1,
    input  logic        rx_q2,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  lat,
    output logic [15:0] err_cnt
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_ALIGN  = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [6:0]  SEED_EFF    = (SEED == 7'd0) ? 7'h7F : SEED;
    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] ALIGN_LAST  = 16'(ALIGN_LEN - 1);
    localparam logic [15:0] CHECK_LAST  = 16'(CHECK_LEN - 1);
    localparam logic [2:0]  LAT_MAX     = 3'(MAX_LAT);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  lat_q, lat_d;
    logic [15:0] err_q, err_d;
    logic        done_q, done_d, pass_q, pass_d;
    logic        busy_q, busy_d, rst_q, rst_d, ce_q, ce_d;
    logic [6:0]  prbs_q, prbs_d;
    logic [1:0]  tx_q, tx_d;
    logic [1:0]  hist_q [0:MAX_LAT];
    logic        rx_match_s;
    logic [15:0] err_inc_s;

    // Two PRBS7 (x^7+x^6+1) steps per cycle; the pair is {first, second} new bit.
    always_comb begin
        tx_d   = {prbs_q[6] ^ prbs_q[5], prbs_q[5] ^ prbs_q[4]};
        prbs_d = {prbs_q[4:0], tx_d};
    end

    assign rx_match_s = ({rx_q1, rx_q2} == hist_q[lat_q]);
    assign err_inc_s  = (!rx_match_s && (err_q != 16'hFFFF)) ? (err_q + 16'd1) : err_q;

    // Sequencer next-state and result bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        err_d   = err_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 16'd0;
                    lat_d   = 3'd0;
                    cnt_d   = 16'd0;
                    state_d = S_RESET;
                end else begin
                    state_d = state_q;
                end
            end
            S_RESET: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_ALIGN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ALIGN: begin
                if (rx_match_s) begin
                    if (cnt_q == ALIGN_LAST) begin
                        cnt_d   = 16'd0;
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = 16'd0;
                    if (lat_q == LAT_MAX) begin
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                        err_d   = 16'd0;
                        state_d = S_DONE;
                    end else begin
                        lat_d = lat_q + 3'd1;
                    end
                end
            end
            S_CHECK: begin
                err_d = err_inc_s;
                if (cnt_q == CHECK_LAST) begin
                    cnt_d   = 16'd0;
                    done_d  = 1'b1;
                    pass_d  = (err_inc_s == 16'd0);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output controls are decoded from the next state so they stay registered.
    always_comb begin
        busy_d = 1'b0;
        ce_d   = 1'b0;
        case (state_d)
            S_RESET:                    busy_d = 1'b1;
            S_SETTLE, S_ALIGN, S_CHECK: begin
                busy_d = 1'b1;
                ce_d   = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                ce_d   = 1'b0;
            end
        endcase
        rst_d = ~ce_d;
    end

    // Control and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            lat_q   <= 3'd0;
            err_q   <= 16'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            rst_q   <= 1'b1;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            rst_q   <= rst_d;
            ce_q    <= ce_d;
        end
    end

    // Pattern source and transmit history; frozen whenever CE is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prbs_q <= SEED_EFF;
            tx_q   <= 2'b00;
            for (int k = 0; k <= MAX_LAT; k++) hist_q[k] <= 2'b00;
        end else if (state_q == S_RESET) begin
            prbs_q <= SEED_EFF;
            tx_q   <= 2'b00;
            for (int k = 0; k <= MAX_LAT; k++) hist_q[k] <= 2'b00;
        end else if (ce_q) begin
            prbs_q    <= prbs_d;
            tx_q      <= tx_d;
            hist_q[0] <= tx_d;
            for (int k = 1; k <= MAX_LAT; k++) hist_q[k] <= hist_q[k-1];
        end
    end

    assign iddr_rst = rst_q;
    assign iddr_ce  = ce_q;
    assign tx_d1    = tx_q[1];
    assign tx_d2    = tx_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign lat      = lat_q;
    assign err_cnt  = err_q;
endmodule

// File: tb/tb_iddr_loopback_sequencer.sv
// Self-checking bench: external pad loopback with programmable delay and bit
// injection, against a sequence-level model of the latency search and check.
module tb_iddr_loopback_sequencer;
    localparam int         RST_CYCLES    = 4;
    localparam int         SETTLE_CYCLES = 16;
    localparam int         ALIGN_LEN     = 16;
    localparam int         MAX_LAT       = 7;
    localparam int         CHECK_LEN     = 256;
    localparam logic [6:0] SEED          = 7'h7F;
    localparam int         HLEN          = 2048;

    logic        clk;
    logic        rst;
    logic        start;
    logic        iddr_rst, iddr_ce, tx_d1, tx_d2, rx_q1, rx_q2;
    logic        busy, done, pass;
    logic [2:0]  lat;
    logic [15:0] err_cnt;

    iddr_loopback_sequencer #(
        .RST_CYCLES(RST_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES), .ALIGN_LEN(ALIGN_LEN),
        .MAX_LAT(MAX_LAT), .CHECK_LEN(CHECK_LEN), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .iddr_rst(iddr_rst), .iddr_ce(iddr_ce),
        .tx_d1(tx_d1), .tx_d2(tx_d2), .rx_q1(rx_q1), .rx_q2(rx_q2), .busy(busy),
        .done(done), .pass(pass), .lat(lat), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] txm  [0:HLEN-1];
    logic [1:0] inj  [0:HLEN-1];
    logic [1:0] pipe [0:7];
    int         delay = 1;
    bit         zero_mode = 1'b0;
    int         ce_idx;
    logic [1:0] rx_pair;
    bit         exp_locked;
    int         exp_lat, exp_cs, exp_end, exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Index of the current CE-high cycle since CE rose.
    always @(posedge clk or posedge rst) begin
        if (rst) ce_idx <= 0;
        else if (iddr_ce) ce_idx <= ce_idx + 1;
        else ce_idx <= 0;
    end

    // Pad loopback: one register per cycle of flight time.
    always @(posedge clk) begin
        pipe[0] <= {tx_d1, tx_d2};
        for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    always_comb begin
        rx_pair = 2'b00;
        if (!zero_mode) rx_pair = pipe[delay-1];
        if (iddr_ce && ce_idx < HLEN) rx_pair = rx_pair ^ inj[ce_idx];
    end
    assign rx_q1 = rx_pair[1];
    assign rx_q2 = rx_pair[0];

    // Expected tx pair on CE cycle i: PRBS7 generated one bit at a time.
    task automatic build_prbs();
        logic [6:0] s;
        logic       b1, b2;
        s = (SEED == 7'd0) ? 7'h7F : SEED;
        txm[0] = 2'b00;
        for (int i = 1; i < HLEN; i++) begin
            b1 = s[6] ^ s[5]; s = {s[5:0], b1};
            b2 = s[6] ^ s[5]; s = {s[5:0], b2};
            txm[i] = {b1, b2};
        end
    endtask

    task automatic clear_inj();
        for (int i = 0; i < HLEN; i++) inj[i] = 2'b00;
    endtask

    function automatic logic [1:0] sent(input int t, input int k);
        return (t >= k) ? txm[t-k] : 2'b00;
    endfunction

    function automatic logic [1:0] rcvd(input int t);
        logic [1:0] r;
        r = zero_mode ? 2'b00 : sent(t, delay);
        return r ^ inj[t];
    endfunction

    // First candidate with ALIGN_LEN clean pairs wins; a mismatch moves on.
    task automatic predict();
        int t, l, run;
        t = SETTLE_CYCLES; l = 0; run = 0; exp_locked = 1'b0;
        while (t < HLEN - CHECK_LEN - 1) begin
            if (rcvd(t) == sent(t, l)) begin
                run++; t++;
                if (run == ALIGN_LEN) begin exp_locked = 1'b1; break; end
            end else begin
                run = 0; t++;
                if (l == MAX_LAT) break;
                l++;
            end
        end
        exp_lat = l; exp_cs = t; exp_err = 0; exp_end = t;
        if (exp_locked) begin
            for (int u = t; u < t + CHECK_LEN; u++)
                if (rcvd(u) != sent(u, l)) exp_err++;
            exp_end = t + CHECK_LEN;
        end
    endtask

    task automatic reset_checks();
        chk("rst_iddr_rst", 32'(iddr_rst), 32'd1);
        chk("rst_iddr_ce", 32'(iddr_ce), 32'd0);
        chk("rst_tx", 32'({tx_d1, tx_d2}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_lat", 32'(lat), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
    endtask

    task automatic run_scn(input int start_at, input int rst_at);
        int waits;
        bit seen_ce;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        waits = 0; seen_ce = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            if (!seen_ce) begin
                if (iddr_ce) begin
                    seen_ce = 1'b1;
                    chk("reset_len", 32'(waits), 32'(RST_CYCLES));
                    chk("rst_low_with_ce", 32'(iddr_rst), 32'd0);
                end else begin
                    waits++;
                    chk("rst_high_in_reset", 32'(iddr_rst), 32'd1);
                end
            end
            if (iddr_ce && ce_idx < HLEN) chk("tx_prbs", 32'({tx_d1, tx_d2}), 32'(txm[ce_idx]));
            if (rst_at >= 0 && iddr_ce && ce_idx == rst_at) begin
                rst = 1'b1;
                #1;
                reset_checks();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            start = (start_at >= 0 && iddr_ce && ce_idx == start_at);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_timeout", 32'(done), 32'd1);
        if (done) begin
            chk("ce_cycles", 32'(ce_idx), 32'(exp_end));
            chk("lat", 32'(lat), 32'(exp_lat));
            chk("pass", 32'(pass), 32'(exp_locked && exp_err == 0));
            chk("err_cnt", 32'(err_cnt), 32'(exp_err));
            chk("tx_frozen", 32'({tx_d1, tx_d2}), 32'(txm[exp_end]));
            chk("done_iddr_rst", 32'(iddr_rst), 32'd1);
            chk("done_iddr_ce", 32'(iddr_ce), 32'd0);
            chk("done_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int d, n, sp;
        rst = 1'b1; start = 1'b0;
        clear_inj();
        build_prbs();
        repeat (2) @(negedge clk);
        reset_checks();
        rst = 1'b0;

        delay = 1; predict(); run_scn(-1, -1);
        chk("plan_lat_d1", 32'(lat), 32'd1);
        chk("plan_pass_d1", 32'(pass), 32'd1);

        delay = 5; predict(); run_scn(-1, -1);
        chk("plan_lat_d5", 32'(lat), 32'd5);

        zero_mode = 1'b1; predict(); run_scn(-1, -1);
        chk("plan_lat_zero", 32'(lat), 32'd7);
        chk("plan_pass_zero", 32'(pass), 32'd0);
        zero_mode = 1'b0;

        delay = 2; clear_inj(); predict();
        inj[exp_cs + 10] = 2'b01; inj[exp_cs + 200] = 2'b01;
        predict(); run_scn(-1, -1);
        chk("plan_err_two", 32'(err_cnt), 32'd2);

        clear_inj(); predict();
        inj[exp_cs + 50] = 2'b11;
        predict(); run_scn(-1, -1);
        chk("plan_err_double_bit", 32'(err_cnt), 32'd1);

        delay = 3; clear_inj(); predict(); run_scn(-1, exp_cs + 100);
        delay = 2; predict(); run_scn(-1, -1);
        chk("plan_pass_after_abort", 32'(pass), 32'd1);

        delay = 4; predict(); run_scn(SETTLE_CYCLES + 2, -1);

        for (int r = 0; r < 5; r++) begin
            d = int'($urandom_range(1, 7));
            delay = d; clear_inj(); predict();
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++)
                inj[exp_cs + int'($urandom_range(0, CHECK_LEN - 1))] = 2'($urandom_range(1, 3));
            predict();
            sp = int'($urandom_range(1, exp_end - 1));
            run_scn(sp, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/iddr_loopback_sequencer.md
Name: iddr_loopback_sequencer

Overview:
- Self-checking controller for an IDDR capture path in the IOLOGIC test designs.
- Generates a PRBS7 bit-pair stream for an ODDR whose pad is looped back externally to the IDDR input.
- Sequences the IDDR reset (R) and clock enable (CE), then searches capture latency 0..MAX_LAT and checks CHECK_LEN received pairs.
- Reports pass/fail, locked latency and a saturating error count to LEDs or pins; sits in the same clock domain as the IDDR C input.

Parameters:
- RST_CYCLES, 4: cycles the IDDR reset is held in RESET state (>=1).
- SETTLE_CYCLES, 16: cycles with CE high before alignment starts (>=1).
- ALIGN_LEN, 16: consecutive matching pairs required to lock a latency candidate (>=1).
- MAX_LAT, 7: largest latency candidate, in clk cycles (1..7).
- CHECK_LEN, 256: pairs compared in CHECK state (1..65535).
- SEED, 7'h7F: PRBS7 initial state; a value of 0 is replaced by 7'h7F.

Ports:
- clk  in  1  system clock; same net as the IDDR C input and the ODDR C input.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a run.
- iddr_rst  out  1  drives IDDR R.
- iddr_ce  out  1  drives IDDR CE and ODDR CE.
- tx_d1  out  1  ODDR D1 (rising-edge bit).
- tx_d2  out  1  ODDR D2 (falling-edge bit).
- rx_q1  in  1  IDDR Q1.
- rx_q2  in  1  IDDR Q2 (SAME_EDGE_PIPELINED mode).
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  run finished; level held until the next accepted start.
- pass  out  1  valid when done=1; high only if alignment locked and err_cnt==0.
- lat  out  3  locked latency, or the last candidate tried on failure.
- err_cnt  out  16  mismatches counted in CHECK; saturates at 16'hFFFF.

Behaviour:
- Async reset: state=IDLE, iddr_rst=1, iddr_ce=0, tx_d1=tx_d2=0, busy=0, done=0, pass=0, lat=0, err_cnt=0, PRBS=SEED.
- All outputs are registered.
- PRBS7 polynomial: x^7+x^6+1.
  - Advances 2 steps per cycle while iddr_ce=1.
  - tx_d1 = first new bit, tx_d2 = second new bit.
  - Holds its value when iddr_ce=0.
- A history shift register holds the last MAX_LAT+1 transmitted pairs. Entry k is the pair sent k cycles ago, with entry 0 = the current tx pair. It shifts only when iddr_ce=1.
- IDLE: iddr_rst=1, iddr_ce=0. On start: clear done, pass and err_cnt; set lat=0; go to RESET.
- DONE: outputs held. Treats start exactly as IDLE does.
- RESET: iddr_rst=1, iddr_ce=0, PRBS reloaded to SEED, history cleared. After RST_CYCLES cycles, go to SETTLE.
- SETTLE: iddr_rst=0, iddr_ce=1. After SETTLE_CYCLES cycles, go to ALIGN with match counter=0.
- ALIGN: each cycle compare {rx_q1,rx_q2} with history entry lat.
  - Match: increment the counter. When it reaches ALIGN_LEN, go to CHECK with lat held.
  - Mismatch: reset the counter.
    - If lat<MAX_LAT, increment lat and continue.
    - If lat==MAX_LAT, go to DONE with pass=0 and err_cnt=0.
- CHECK: CHECK_LEN compare cycles against history entry lat.
  - Each mismatching pair adds 1 to err_cnt, not 2 for a double-bit error.
  - After the last compare cycle, go to DONE; pass = (err_cnt==0), including a mismatch on that final cycle.
- DONE: iddr_ce=0, iddr_rst=1, tx bits frozen, done=1.
- start asserted while busy=1 is ignored.
- rst asserted mid-run aborts immediately to the reset values; no partial results are kept.
- Latency search is linear and takes the first candidate that locks. Worst-case alignment time is (MAX_LAT+1)*ALIGN_LEN cycles.

Test Plan:
- Loopback model with 1-cycle delay, pulse start -> RESET for 4 cycles, SETTLE for 16, then lock at lat=1; after 256 checks done=1, pass=1, err_cnt=0.
- Loopback delay 5 cycles -> lat=5, pass=1, err_cnt=0; verify iddr_rst deasserts in the same cycle iddr_ce rises.
- rx_q1=rx_q2=0 constant -> all 8 candidates rejected; done=1, pass=0, lat=7, err_cnt=0.
- 2-cycle delay, invert rx_q2 on CHECK cycles 10 and 200 -> pass=0, err_cnt=2; invert both bits on one cycle -> err_cnt=1.
- Assert rst during CHECK cycle 100 -> outputs return to reset values at once; a new start gives a full clean run with pass=1.
- Pulse start during ALIGN -> no effect; pulse start in DONE -> done clears and a new run begins.
